prbs_xnor_checker: RTL and testbench

PRBS_XNOR_CHECKER -- requirements
Module: prbs_xnor_checker

---
 rtl/prbs_xnor_pkg.sv | 29 ++
 rtl/xnor_lfsr_step.sv | 23 ++
 rtl/prbs_xnor_checker.sv | 177 +++++++++++++++++
 tb/tb_prbs_xnor_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_xnor_pkg.sv
// rtl/prbs_xnor_pkg.sv - shared types and constants for the XNOR PRBS generator/checker
package prbs_xnor_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } chk_state_e;

  localparam logic MODE_PRBS7  = 1'b0;
  localparam logic MODE_PRBS15 = 1'b1;

  localparam int PRBS7_LEN  = 7;
  localparam int PRBS15_LEN = 15;
  localparam int LFSR_W     = PRBS15_LEN;

  localparam int PRBS7_TAP_HI  = 6;
  localparam int PRBS7_TAP_LO  = 5;
  localparam int PRBS15_TAP_HI = 14;
  localparam int PRBS15_TAP_LO = 13;

  localparam int ERR_CNT_W = 16;

  // Value of the fill counter on the last bit needed to populate the register
  function automatic logic [3:0] fill_last(input logic mode);
    return (mode == MODE_PRBS15) ? 4'(PRBS15_LEN - 1) : 4'(PRBS7_LEN - 1);
  endfunction

endpackage

// File: rtl/xnor_lfsr_step.sv
// rtl/xnor_lfsr_step.sv - one-bit step of the XNOR LFSR for the selected polynomial
module xnor_lfsr_step
  import prbs_xnor_pkg::*;
(
  input  logic              mode,
  input  logic [LFSR_W-1:0] cur,
  input  logic              din,
  output logic              fb,
  output logic              all_ones,
  output logic [LFSR_W-1:0] nxt
);

  // Kept as separate continuous assigns so a caller may feed fb straight back into din
  assign fb = (mode == MODE_PRBS15) ? ~(cur[PRBS15_TAP_HI] ^ cur[PRBS15_TAP_LO])
                                    : ~(cur[PRBS7_TAP_HI] ^ cur[PRBS7_TAP_LO]);

  assign all_ones = (mode == MODE_PRBS15) ? (&cur[PRBS15_LEN-1:0]) : (&cur[PRBS7_LEN-1:0]);

  // PRBS7 keeps the unused upper bits at zero so all-ones detection stays exact
  assign nxt = (mode == MODE_PRBS15) ? {cur[LFSR_W-2:0], din}
                                     : {{(LFSR_W-PRBS7_LEN){1'b0}}, cur[PRBS7_LEN-2:0], din};

endmodule

// File: rtl/prbs_xnor_checker.sv
// rtl/prbs_xnor_checker.sv - XNOR PRBS7/PRBS15 generator and self-synchronising checker
module prbs_xnor_checker
  import prbs_xnor_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 MODE,
  input  logic                 GEN_EN,
  output logic                 GEN_Q,
  input  logic                 CHK_D,
  input  logic                 CHK_VALID,
  input  logic                 CLR_CNT,
  output logic                 LOCKED,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [5:0] LOCK_THRESH_V = 6'(LOCK_THRESH);
  localparam logic [6:0] LOSS_THRESH_V = 7'(LOSS_THRESH);

  logic                 mode_q, mode_d, mode_chg;
  logic [LFSR_W-1:0]    s_q, s_d, gen_nxt;
  logic                 gen_fb, gen_all_ones;
  logic [LFSR_W-1:0]    r_q, r_d, r_nxt;
  logic                 chk_p, chk_all_ones, chk_din;
  chk_state_e           state_q, state_d;
  logic [3:0]           fill_cnt_q, fill_cnt_d;
  logic [5:0]           match_cnt_q, match_cnt_d;
  logic [5:0]           win_cnt_q, win_cnt_d;
  logic [6:0]           win_err_q, win_err_d;
  logic                 err_q, err_d, bit_err;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign mode_chg = (MODE != mode_q);

  xnor_lfsr_step u_gen_step (
    .mode     (mode_q),
    .cur      (s_q),
    .din      (gen_fb),
    .fb       (gen_fb),
    .all_ones (gen_all_ones),
    .nxt      (gen_nxt)
  );

  // Once locked the checker register free-runs on its own prediction
  assign chk_din = (state_q == ST_LOCK) ? chk_p : CHK_D;

  xnor_lfsr_step u_chk_step (
    .mode     (mode_q),
    .cur      (r_q),
    .din      (chk_din),
    .fb       (chk_p),
    .all_ones (chk_all_ones),
    .nxt      (r_nxt)
  );

  // Generator next state: mode change or XNOR lockup forces all-zeros
  always_comb begin
    mode_d = MODE;
    s_d    = s_q;
    if (mode_chg || gen_all_ones) begin
      s_d = '0;
    end else if (GEN_EN) begin
      s_d = gen_nxt;
    end
  end

  // Checker next state and counters
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_err     = 1'b0;
    if (mode_chg) begin
      state_d     = ST_FILL;
      r_d         = '0;
      fill_cnt_d  = '0;
      match_cnt_d = '0;
      win_cnt_d   = '0;
      win_err_d   = '0;
    end else if (CHK_VALID) begin
      unique case (state_q)
        ST_FILL: begin
          r_d = r_nxt;
          if (fill_cnt_q == fill_last(mode_q)) begin
            state_d     = ST_HUNT;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 4'd1;
          end
        end
        ST_HUNT: begin
          r_d = r_nxt;
          if (!chk_all_ones && (CHK_D == chk_p)) begin
            match_cnt_d = match_cnt_q + 6'd1;
            if (match_cnt_d == LOCK_THRESH_V) begin
              state_d   = ST_LOCK;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        ST_LOCK: begin
          bit_err   = (CHK_D != chk_p);
          win_err_d = bit_err ? (win_err_q + 7'd1) : win_err_q;
          if (win_err_d >= LOSS_THRESH_V) begin
            state_d     = ST_HUNT;
            match_cnt_d = '0;
            r_d         = {r_nxt[LFSR_W-1:1], CHK_D};
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            r_d       = r_nxt;
            win_cnt_d = win_cnt_q + 6'd1;
            if (win_cnt_q == 6'd63) begin
              win_err_d = '0;
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
    err_d = bit_err;
    if (CLR_CNT) begin
      err_cnt_d = '0;
    end else if (bit_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State register; the mode copy loads the live MODE in reset so release is not a mode change
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q      <= MODE;
      s_q         <= '0;
      r_q         <= '0;
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      s_q         <= s_d;
      r_q         <= r_d;
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Outputs straight from registered state
  always_comb begin
    GEN_Q   = (mode_q == MODE_PRBS15) ? s_q[PRBS15_LEN-1] : s_q[PRBS7_LEN-1];
    LOCKED  = (state_q == ST_LOCK);
    ERR     = err_q;
    ERR_CNT = err_cnt_q;
  end

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// tb/tb_prbs_xnor_checker.sv - self-checking bench for prbs_xnor_checker
module tb_prbs_xnor_checker;

  localparam int LOCK_T = 16;
  localparam int LOSS_T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        gen_en = 1'b0;
  logic        chk_d = 1'b0;
  logic        chk_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        gen_q, locked, err;
  logic [15:0] err_cnt;

  int n_asserts = 0;
  int n_fail = 0;
  int n_err_seen = 0;

  int   src_sel = 0;
  logic const_d = 1'b1;
  int   src_k = 0;

  bit gb7[127];
  bit gb15[32767];

  int m_phase, m_fill, m_match, m_win, m_werr, m_cnt, m_gidx;
  bit m_err, m_mode_q;
  bit m_hist[$];

  prbs_xnor_checker #(.LOCK_THRESH(LOCK_T), .LOSS_THRESH(LOSS_T)) dut (
    .CLK(clk), .RST(rst), .MODE(mode), .GEN_EN(gen_en), .GEN_Q(gen_q),
    .CHK_D(chk_d), .CHK_VALID(chk_valid), .CLR_CNT(clr_cnt),
    .LOCKED(locked), .ERR(err), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic build_seqs();
    for (int k = 0; k < 127; k++) begin
      if (k < 7) gb7[k] = 1'b0;
      else gb7[k] = !(gb7[k-7] ^ gb7[k-6]);
    end
    for (int k = 0; k < 32767; k++) begin
      if (k < 15) gb15[k] = 1'b0;
      else gb15[k] = !(gb15[k-15] ^ gb15[k-14]);
    end
  endtask

  function automatic bit seq_bit(input bit md, input int idx);
    if (md) return gb15[idx % 32767];
    return gb7[idx % 127];
  endfunction

  task automatic chk_restart();
    int n;
    n = m_mode_q ? 15 : 7;
    m_phase = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_hist.delete();
    for (int i = 0; i < n; i++) m_hist.push_back(1'b0);
  endtask

  task automatic m_shift(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_clock(input bit r, input bit md, input bit ge, input bit v, input bit d, input bit clr);
    int n;
    bit p, ones, e;
    if (r) begin
      m_mode_q = md; m_gidx = 0; m_cnt = 0; m_err = 0;
      chk_restart();
      return;
    end
    if (md != m_mode_q) begin
      m_mode_q = md; m_gidx = 0; m_err = 0;
      chk_restart();
      if (clr) m_cnt = 0;
      return;
    end
    if (ge) m_gidx++;
    n = m_mode_q ? 15 : 7;
    e = 1'b0;
    if (v) begin
      p = !(m_hist[0] ^ m_hist[1]);
      ones = 1'b1;
      foreach (m_hist[i]) if (!m_hist[i]) ones = 1'b0;
      if (m_phase == 0) begin
        m_shift(d);
        m_fill++;
        if (m_fill == n) begin m_phase = 1; m_fill = 0; m_match = 0; end
      end else if (m_phase == 1) begin
        if (!ones && d == p) m_match++;
        else m_match = 0;
        m_shift(d);
        if (m_match == LOCK_T) begin m_phase = 2; m_win = 0; m_werr = 0; end
      end else begin
        if (d != p) begin e = 1'b1; m_werr++; end
        if (m_werr >= LOSS_T) begin
          m_phase = 1; m_match = 0; m_win = 0; m_werr = 0;
          m_shift(d);
        end else begin
          m_shift(p);
          m_win++;
          if (m_win == 64) begin m_win = 0; m_werr = 0; end
        end
      end
    end
    m_err = e;
    if (clr) m_cnt = 0;
    else if (e && m_cnt < 65535) m_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: apply one cycle of inputs, step the model, check after the edge
  task automatic run_bit(input bit valid, input bit inv, input bit clr);
    bit d;
    case (src_sel)
      0: d = gen_q;
      1: d = const_d;
      default: d = seq_bit(mode, src_k);
    endcase
    if (valid && src_sel == 2) src_k++;
    chk_valid = valid;
    chk_d = d ^ inv;
    clr_cnt = clr;
    model_clock(rst, mode, gen_en, valid, chk_d, clr);
    @(posedge clk);
    @(negedge clk);
    if (err === 1'b1) n_err_seen++;
    check("locked", {31'b0, locked}, {31'b0, m_phase == 2});
    check("err", {31'b0, err}, {31'b0, m_err});
    check("err_cnt", {16'b0, err_cnt}, m_cnt);
    check("gen_q", {31'b0, gen_q}, {31'b0, seq_bit(m_mode_q, m_gidx)});
  endtask

  initial begin
    int first_lock;
    build_seqs();
    @(negedge clk);

    // Reset state
    rst = 1'b1;
    run_bit(0, 0, 0);
    run_bit(0, 0, 0);
    check("rst_locked", {31'b0, locked}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_err_cnt", {16'b0, err_cnt}, 0);
    check("rst_gen_q", {31'b0, gen_q}, 0);
    rst = 1'b0;

    // PRBS7 loopback: generator sequence and lock timing
    gen_en = 1'b1;
    src_sel = 0;
    first_lock = 0;
    for (int i = 1; i <= 1000; i++) begin
      run_bit(1, 0, 0);
      if (locked === 1'b1 && first_lock == 0) first_lock = i;
    end
    check("prbs7_lock_bit", first_lock, 23);
    check("prbs7_err_cnt", {16'b0, err_cnt}, 0);

    // Switch to PRBS15, lock, then a single inverted bit
    mode = 1'b1;
    run_bit(1, 0, 0);
    check("mode_chg_locked", {31'b0, locked}, 0);
    for (int i = 0; i < 80; i++) run_bit(1, 0, 0);
    check("prbs15_locked", {31'b0, locked}, 1);
    n_err_seen = 0;
    run_bit(1, 1, 0);
    for (int i = 0; i < 50; i++) run_bit(1, 0, 0);
    check("single_err_pulses", n_err_seen, 1);
    check("single_err_cnt", {16'b0, err_cnt}, 1);
    check("single_err_locked", {31'b0, locked}, 1);

    // Eight errors in a window drop lock; clean stream relocks
    for (int i = 0; i < 8; i++) run_bit(1, 1, 0);
    check("loss_locked", {31'b0, locked}, 0);
    for (int i = 0; i < 60; i++) run_bit(1, 0, 0);
    check("relock", {31'b0, locked}, 1);

    // Saturation and clear-wins
    force dut.err_cnt_q = 16'hFFFF;
    #1;
    release dut.err_cnt_q;
    m_cnt = 65535;
    run_bit(1, 1, 0);
    check("sat_err_cnt", {16'b0, err_cnt}, 32'hFFFF);
    run_bit(1, 1, 1);
    check("clr_wins", {16'b0, err_cnt}, 0);

    // Reset while locked
    check("pre_rst_locked", {31'b0, locked}, 1);
    rst = 1'b1;
    mode = 1'b0;
    run_bit(1, 0, 0);
    check("rst_lock_locked", {31'b0, locked}, 0);
    check("rst_lock_err_cnt", {16'b0, err_cnt}, 0);
    check("rst_lock_gen_q", {31'b0, gen_q}, 0);
    rst = 1'b0;

    // Constant-one input never locks
    src_sel = 1;
    const_d = 1'b1;
    for (int i = 0; i < 500; i++) run_bit(1, 0, 0);
    check("ones_no_lock", {31'b0, locked}, 0);

    // Randomised traffic with gaps, sparse bit errors and clears, both modes
    src_sel = 2;
    src_k = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin mode = 1'b1; src_k = 0; end
      gen_en = ($urandom_range(0, 9) != 0);
      run_bit($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
